systolic_result_drain: RTL and testbench

- Reader-side counterpart to the `systolic_array` result port.
- When `compute_done` rises, it snapshots the flat `pe_register_vals` vector and streams the results out one word per cycle over a valid/ready handshake.
- Output order is column-major, matching the order in which the team's result files and checkers store output matrices.
- Sits between the array and the result memory or host interface, and frees the array for the next tile while draining.

---
 rtl/systolic_result_drain.sv | 85 ++++++++
 tb/tb_systolic_result_drain.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array result vector when compute_done rises and
// streams it column-major over a valid/ready handshake, one word per cycle.
module systolic_result_drain #(
  parameter int out_word_size = 24,
  parameter int num_row = 4,
  parameter int num_col = 2,
  localparam int NW = num_row * num_col,
  localparam int IW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        compute_done,
  input  logic [out_word_size*NW-1:0] pe_register_vals,
  output logic [out_word_size-1:0]    out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IW-1:0]               out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic                        overrun,
  output logic [out_word_size-1:0]    frame_count
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  logic [0:0]               state;
  logic                     done_q;
  logic [out_word_size-1:0] snap [NW];
  logic [IW-1:0]            p;
  logic [IW-1:0]            flat;
  logic                     start;
  logic                     hs;
  logic                     fin;

  assign start = compute_done & ~done_q;
  assign hs    = (state == DRAIN) & out_ready;
  assign fin   = hs & (p == LAST);

  // Column-major walk: row index cycles fastest through the row-major snapshot.
  always_comb begin
    flat = IW'(((int'(p) % num_row) * num_col) + (int'(p) / num_row));
  end

  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_index = p;
  assign out_data  = snap[flat];
  assign out_last  = out_valid & (p == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      p           <= '0;
      overrun     <= 1'b0;
      frame_count <= '0;
      for (int k = 0; k < NW; k++) begin
        snap[k] <= '0;
      end
    end else begin
      done_q <= compute_done;
      if (fin) begin
        frame_count <= frame_count + out_word_size'(1);
      end
      if (start & (state == DRAIN) & ~fin) begin
        overrun <= 1'b1;
      end
      // A start on the final handshake chains straight into the next frame.
      if (start & ((state == IDLE) | fin)) begin
        for (int k = 0; k < NW; k++) begin
          snap[k] <= pe_register_vals[(NW-1-k)*out_word_size +: out_word_size];
        end
        p     <= '0;
        state <= DRAIN;
      end else if (fin) begin
        state <= IDLE;
      end else if (hs) begin
        p <= p + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: table-driven frames plus
// hand-written overrun, coincident-restart and reset sequences.
module tb_systolic_result_drain;

  localparam int W  = 24;
  localparam int M  = 4;
  localparam int N  = 2;
  localparam int NW = 8;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            compute_done;
  logic [W*NW-1:0] pe;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_index;
  logic            out_last;
  logic            busy;
  logic            overrun;
  logic [W-1:0]    frame_count;

  systolic_result_drain #(
    .out_word_size(W),
    .num_row(M),
    .num_col(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .compute_done(compute_done),
    .pe_register_vals(pe),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_last(out_last),
    .busy(busy),
    .overrun(overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ready;
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          last;
  } vec_t;

  vec_t tab[$];
  int n_run = 0;
  int n_fail = 0;

  logic [W-1:0] exp_cm [NW] = '{
    24'h01, 24'h11, 24'h21, 24'h31,
    24'h02, 24'h12, 24'h22, 24'h32
  };
  logic [W-1:0] exp_new [NW] = '{
    24'h100, 24'h102, 24'h104, 24'h106,
    24'h101, 24'h103, 24'h105, 24'h107
  };

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic load_base();
    for (int k = 0; k < NW; k++) begin
      pe[(NW-1-k)*W +: W] = W'(16 * (k / N) + (k % N) + 1);
    end
  endtask

  task automatic load_alt(input logic [W-1:0] base);
    for (int k = 0; k < NW; k++) begin
      pe[(NW-1-k)*W +: W] = base + W'(k);
    end
  endtask

  // ready asserted every 'period' cycles, starting with the first word
  task automatic build(input int period);
    vec_t v;
    int idx;
    int c;
    tab.delete();
    idx = 0;
    c = 0;
    while (idx < NW) begin
      v.ready = ((c % period) == 0);
      v.data  = exp_cm[idx];
      v.idx   = IW'(idx);
      v.last  = (idx == NW - 1);
      tab.push_back(v);
      if (v.ready) idx++;
      c++;
    end
  endtask

  task automatic run_frame(input int exp_frames);
    compute_done = 1'b1;
    out_ready = 1'b0;
    step();
    compute_done = 1'b0;
    foreach (tab[i]) begin
      out_ready = tab[i].ready;
      chk("tab_valid", 32'(out_valid), 1);
      chk("tab_data", 32'(out_data), 32'(tab[i].data));
      chk("tab_index", 32'(out_index), 32'(tab[i].idx));
      chk("tab_last", 32'(out_last), 32'(tab[i].last));
      step();
    end
    out_ready = 1'b0;
    chk("tab_end_valid", 32'(out_valid), 0);
    chk("tab_frames", 32'(frame_count), exp_frames);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    compute_done = 1'b0;
    out_ready = 1'b0;
    pe = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_index", 32'(out_index), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_frames", 32'(frame_count), 0);

    load_base();
    build(1);
    run_frame(1);
    chk("basic_overrun", 32'(overrun), 0);

    build(3);
    run_frame(2);
    chk("bp_overrun", 32'(overrun), 0);

    do_reset();
    compute_done = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    repeat (30) begin
      step();
      if (out_valid) cnt++;
    end
    chk("level_valid_cycles", 32'(cnt), 8);
    chk("level_frames", 32'(frame_count), 1);
    chk("level_overrun", 32'(overrun), 0);
    compute_done = 1'b0;
    step();

    do_reset();
    load_base();
    compute_done = 1'b1;
    out_ready = 1'b1;
    step();
    compute_done = 1'b0;
    for (int i = 0; i < NW; i++) begin
      chk("ovr_valid", 32'(out_valid), 1);
      chk("ovr_index", 32'(out_index), i);
      chk("ovr_data", 32'(out_data), 32'(exp_cm[i]));
      if (i >= 4) chk("ovr_flag", 32'(overrun), 1);
      if (i == 3) begin
        compute_done = 1'b1;
        load_alt(24'hAAA000);
      end
      step();
    end
    chk("ovr_end_valid", 32'(out_valid), 0);
    chk("ovr_frames", 32'(frame_count), 1);
    chk("ovr_flag_end", 32'(overrun), 1);
    step();
    chk("ovr_no_retrigger", 32'(out_valid), 0);
    compute_done = 1'b0;
    step();
    chk("ovr_sticky", 32'(overrun), 1);

    do_reset();
    load_base();
    compute_done = 1'b1;
    out_ready = 1'b1;
    step();
    compute_done = 1'b0;
    for (int i = 0; i < NW; i++) begin
      chk("coin_a_valid", 32'(out_valid), 1);
      chk("coin_a_data", 32'(out_data), 32'(exp_cm[i]));
      if (i == 7) begin
        compute_done = 1'b1;
        load_alt(24'h100);
      end
      step();
    end
    compute_done = 1'b0;
    for (int i = 0; i < NW; i++) begin
      chk("coin_b_valid", 32'(out_valid), 1);
      chk("coin_b_index", 32'(out_index), i);
      chk("coin_b_data", 32'(out_data), 32'(exp_new[i]));
      if (i == 0) begin
        chk("coin_frames_1", 32'(frame_count), 1);
        chk("coin_overrun", 32'(overrun), 0);
      end
      step();
    end
    chk("coin_end_valid", 32'(out_valid), 0);
    chk("coin_frames_2", 32'(frame_count), 2);
    chk("coin_overrun_end", 32'(overrun), 0);

    load_base();
    compute_done = 1'b1;
    out_ready = 1'b1;
    step();
    compute_done = 1'b0;
    repeat (5) step();
    chk("mid_index", 32'(out_index), 5);
    reset = 1'b1;
    #1;
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_frames", 32'(frame_count), 0);
    chk("mid_index_rst", 32'(out_index), 0);
    compute_done = 1'b1;
    #2;
    reset = 1'b0;
    step();
    compute_done = 1'b0;
    for (int i = 0; i < NW; i++) begin
      chk("post_valid", 32'(out_valid), 1);
      chk("post_index", 32'(out_index), i);
      chk("post_data", 32'(out_data), 32'(exp_cm[i]));
      step();
    end
    chk("post_frames", 32'(frame_count), 1);
    chk("post_end_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
